regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file for the nano_rv32i core, succeeding the fixed 32x32 two-read register file. It adds configurable width, depth and read-port count, optional same-cycle write-to-read bypass, and a sequential clear engine instead of a flop-wide reset, so the storage array can map to RAM-style cells. It sits between decode (read addresses) and writeback (write port).

## Interface
- `XLEN`, 32: register width in bits.
- `NREGS`, 32: register count, power of two, >= 4; `AW = $clog2(NREGS)`.
- `NUM_RD`, 2: number of read ports, 1..4.
- `BYPASS`, 1: 1 means a same-cycle write is forwarded to matching reads; 0 means reads return old contents.
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `clear_i`, in, 1: synchronous request to re-zero all registers.
- `enable_i`, in, 1: write qualifier.
- `reg_write_i`, in, 1: write request.
- `rd_i`, in, AW: write address.
- `write_data_i`, in, XLEN: write data.
- `rs_i`, in, NUM_RD*AW: read addresses; port k is at slice [k*AW +: AW].
- `rs_data_o`, out, NUM_RD*XLEN: read data; port k is at slice [k*XLEN +: XLEN].
- `busy_o`, out, 1: clear in progress.

## Operation
- Register 0 is hardwired: reads of address 0 always return 0, and writes to address 0 are dropped. Storage for index 0 is optional.
- The FSM has two states, IDLE and CLEAR. A clear index `clr_idx` (AW bits) walks the array.
- `rst_i` asserted:
  - State becomes CLEAR, `clr_idx` = 1, `busy_o` = 1, asynchronously.
  - Array contents are not reset directly.
- CLEAR state:
  - Each rising edge writes 0 to `clr_idx` and increments it.
  - The edge that writes `NREGS-1` moves the FSM to IDLE.
- IDLE state, `clear_i` = 1: moves to CLEAR with `clr_idx` = 1.
- CLEAR state, `clear_i` = 1: restarts `clr_idx` at 1.
- Writes:
  - A write is valid when `enable_i & reg_write_i & (rd_i != 0) & (state == IDLE)`.
  - Writes during CLEAR are discarded silently, with no queueing.
- Reads (combinational, per port k):
  - If state is CLEAR or `rs_k == 0`: 0.
  - Else if `BYPASS` and a write is valid with `rd_i == rs_k`: `write_data_i`.
  - Otherwise: stored value.
- Multiple ports may read the same address; each port returns the same value.
- A write in IDLE in the same cycle as `clear_i`: the write is accepted, then the clear overwrites it.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge; without bypass, the value is visible the cycle after the write.
- Reset values:
  - `busy_o` = 1.
  - `rs_data_o` = all zeros while reset is asserted or the FSM is in CLEAR.
- After `rst_i` deasserts, `busy_o` stays 1 for exactly NREGS-1 rising edges and is 0 after edge NREGS-1.
- `clear_i` sampled at edge E: `busy_o` = 1 from after E, for NREGS-1 further edges.
- `busy_o` is a registered state decode with no combinational path from `clear_i`.
- `rst_i` asserted mid-clear or mid-write forces CLEAR immediately; any partial write is lost.
- The `clr_idx` increment never wraps to 0. Termination is detected at `NREGS-1`.

## Structure
- Package `regfile_pkg` holds:
  - the state enum (`RF_IDLE`, `RF_CLEAR`);
  - a helper function for the `AW` computation.
- Sub-module `regfile_clear_ctrl` holds the FSM, `clr_idx`, `busy_o`, the clear write-enable and the clear address.
- The top level holds the array, the write mux (clear vs. writeback), and a per-port read/bypass generate loop.

## Test plan
Defaults unless stated: XLEN=32, NREGS=32, NUM_RD=2, BYPASS=1.
- Pulse `rst_i`, then release: `busy_o` = 1 for 31 edges, then 0; every read returns 0 throughout and afterwards.
- After the clear, write x5 = 0xDEADBEEF; next cycle read rs0 = 5, rs1 = 5: both ports return 0xDEADBEEF.
- Same cycle, write x7 = 0x12345678 with rs0 = 7:
  - BYPASS=1: returns 0x12345678 that cycle.
  - BYPASS=0: returns the prior value 0, then 0x12345678 the next cycle.
- Write x0 = 0xFFFFFFFF, then read rs0 = 0: returns 0. Write with `enable_i` = 0: no change.
- Fill x1..x31 with their own index, then pulse `clear_i`:
  - `busy_o` rises the next cycle.
  - A write to x3 during CLEAR is dropped.
  - After 31 edges, all registers read 0.
- Assert `rst_i` at clear edge 10, hold it 2 cycles: `busy_o` stays 1, and the clear restarts for a full 31 edges from release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Address width for a register count that is a power of two.
    function automatic int unsigned rf_addr_width(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear engine: walks every register index from 1 to NREGS-1 writing zero,
// entered on reset or on a clear request.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = rf_addr_width(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output rf_state_e     state,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= FIRST_IDX;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            RF_IDLE: begin
                if (clear) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = FIRST_IDX;
                end
            end
            RF_CLEAR: begin
                // The index stops at the last register instead of wrapping to 0.
                if (clear) begin
                    clr_idx_d = FIRST_IDX;
                end else if (clr_idx_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + FIRST_IDX;
                end
            end
        endcase
    end

    assign state    = state_q;
    assign busy     = (state_q == RF_CLEAR);
    assign clr_we   = (state_q == RF_CLEAR);
    assign clr_addr = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_RD combinational read ports, optional
// write-to-read bypass and a sequential clear engine instead of an array reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = rf_addr_width(NREGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic                   reg_write_i,
    input  logic [AW-1:0]          rd_i,
    input  logic [XLEN-1:0]        write_data_i,
    input  logic [NUM_RD*AW-1:0]   rs_i,
    output logic [NUM_RD*XLEN-1:0] rs_data_o,
    output logic                   busy_o
);

    rf_state_e     state;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_valid;

    // No reset on the array so it can map onto RAM-style cells.
    logic [XLEN-1:0] mem [NREGS];

    regfile_clear_ctrl #(
        .NREGS(NREGS)
    ) u_clear_ctrl (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (clear_i),
        .state   (state),
        .busy    (busy_o),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    assign wr_valid = enable_i & reg_write_i & (rd_i != '0) & (state == RF_IDLE);

    // Clear and writeback never overlap: writes are only valid in IDLE.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_valid) begin
            mem[rd_i] <= write_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   rs;
        logic [XLEN-1:0] val;

        assign rs = rs_i[k*AW +: AW];

        always_comb begin
            val = mem[rs];
            if (state == RF_CLEAR || rs == '0) begin
                val = '0;
            end else if (BYPASS != 0 && wr_valid && rd_i == rs) begin
                val = write_data_i;
            end
        end

        assign rs_data_o[k*XLEN +: XLEN] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two DUTs (bypass on/off) share stimulus; a reference model
// predicts reads and busy, and a negedge monitor compares against the queue.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   clear = 1'b0;
    logic                   en = 1'b0;
    logic                   we = 1'b0;
    logic [AW-1:0]          rd = '0;
    logic [XLEN-1:0]        wd = '0;
    logic [NUM_RD*AW-1:0]   rs = '0;
    logic [NUM_RD*XLEN-1:0] rdata_b1, rdata_b0;
    logic                   busy_b1, busy_b0;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(1)
    ) dut_b1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(en), .reg_write_i(we),
        .rd_i(rd), .write_data_i(wd), .rs_i(rs), .rs_data_o(rdata_b1), .busy_o(busy_b1)
    );

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(0)
    ) dut_b0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(en), .reg_write_i(we),
        .rd_i(rd), .write_data_i(wd), .rs_i(rs), .rs_data_o(rdata_b0), .busy_o(busy_b0)
    );

    // Reference model: register contents, busy flag and clear edges remaining.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy = 1'b0;
    int              m_left = 0;
    int              cyc = 0;

    typedef struct {
        int                     cyc;
        logic [NUM_RD*XLEN-1:0] exp_b1;
        logic [NUM_RD*XLEN-1:0] exp_b0;
        logic                   exp_busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic logic [XLEN-1:0] model_read(input int a, input bit byp);
        if (m_busy || a == 0) return '0;
        if (byp && en && we && rd != '0 && int'(rd) == a) return wd;
        return m_regs[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b1;
            m_left = NREGS - 1;
        end else if (!m_busy) begin
            if (en && we && rd != '0) m_regs[rd] = wd;
            if (clear) begin
                m_busy = 1'b1;
                m_left = NREGS - 1;
            end
        end else if (clear) begin
            m_left = NREGS - 1;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            end
        end
    endtask

    task automatic cycle();
        exp_t it;
        if (rst) begin
            m_busy = 1'b1;
            m_left = NREGS - 1;
        end
        it.cyc = cyc;
        for (int k = 0; k < NUM_RD; k++) begin
            it.exp_b1[k*XLEN +: XLEN] = model_read(int'(rs[k*AW +: AW]), 1'b1);
            it.exp_b0[k*XLEN +: XLEN] = model_read(int'(rs[k*AW +: AW]), 1'b0);
        end
        it.exp_busy = m_busy;
        sb.push_back(it);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic drive(input bit c, input bit e, input bit w, input int r,
                         input logic [XLEN-1:0] d, input int a0, input int a1);
        clear = c;
        en    = e;
        we    = w;
        rd    = AW'(r);
        wd    = d;
        rs    = {AW'(a1), AW'(a0)};
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b0, 0, '0, $urandom_range(0, NREGS - 1),
                  $urandom_range(0, NREGS - 1));
    endtask

    task automatic chk(input string name, input int c, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            chk("busy_b1", it.cyc, XLEN'(busy_b1), XLEN'(it.exp_busy));
            chk("busy_b0", it.cyc, XLEN'(busy_b0), XLEN'(it.exp_busy));
            for (int k = 0; k < NUM_RD; k++) begin
                chk($sformatf("rd%0d_b1", k), it.cyc, rdata_b1[k*XLEN +: XLEN],
                    it.exp_b1[k*XLEN +: XLEN]);
                chk($sformatf("rd%0d_b0", k), it.cyc, rdata_b0[k*XLEN +: XLEN],
                    it.exp_b0[k*XLEN +: XLEN]);
            end
        end
    end

    initial begin
        int r;
        @(posedge clk);
        #1;
        // Reset pulse and full clear walk
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(NREGS + 2);

        // Write then dual-port read of the same register
        drive(1'b0, 1'b1, 1'b1, 5, 32'hDEADBEEF, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 5, 5);

        // Same-cycle write/read: bypass versus registered visibility
        drive(1'b0, 1'b1, 1'b1, 7, 32'h12345678, 7, 5);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 7, 7);

        // x0 is hardwired; disabled write is ignored
        drive(1'b0, 1'b1, 1'b1, 0, 32'hFFFFFFFF, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 0, 5);
        drive(1'b0, 1'b0, 1'b1, 9, 32'hCAFEF00D, 9, 9);
        drive(1'b0, 1'b1, 1'b0, 9, 32'hCAFEF00D, 9, 9);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 9, 0);

        // Fill, clear, dropped write during clear, then read everything back
        for (int i = 1; i < NREGS; i++) drive(1'b0, 1'b1, 1'b1, i, XLEN'(i), i, i - 1);
        drive(1'b1, 1'b0, 1'b0, 0, '0, 3, 4);
        drive(1'b0, 1'b1, 1'b1, 3, 32'hAAAA5555, 3, 3);
        idle(NREGS);
        for (int i = 0; i < NREGS; i++) drive(1'b0, 1'b0, 1'b0, 0, '0, i, NREGS - 1 - i);

        // Reset in the middle of a clear restarts the walk
        for (int i = 1; i < NREGS; i++) drive(1'b0, 1'b1, 1'b1, i, XLEN'(i * 3), i, 0);
        drive(1'b1, 1'b0, 1'b0, 0, '0, 1, 2);
        idle(9);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(NREGS + 2);
        for (int i = 0; i < NREGS; i++) drive(1'b0, 1'b0, 1'b0, 0, '0, i, i);

        // Randomised traffic with occasional clears and resets
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, NREGS - 1);
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, r, $urandom,
                  ($urandom_range(0, 2) == 0) ? r : $urandom_range(0, NREGS - 1),
                  ($urandom_range(0, 2) == 0) ? r : $urandom_range(0, NREGS - 1));
            rst = 1'b0;
        end
        idle(2);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
